// File: rtl/raster_timing_gen.sv
// rtl/raster_timing_gen.sv - raster position generator: pixel, hi-res, sprite and xpos counters,
// line counter with interlace, line/frame strobes and raster-compare strobe.
module raster_timing_gen #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int NJUMP = 4
) (
  input  logic                clk_dot4x,
  input  logic                i_rst,
  input  logic                i_clk_phi,
  input  logic                i_dot_rising_0,
  input  logic                i_dot_rising_2,
  input  logic                i_hires_en,
  input  logic                i_interlace_en,
  input  logic [XW-1:0]       i_raster_x_max,
  input  logic [YW-1:0]       i_raster_y_max,
  input  logic [XW-1:0]       i_xpos_start,
  input  logic [XW-1:0]       i_spr_ofs,
  input  logic [NJUMP-1:0]    i_jump_en,
  input  logic [NJUMP*XW-1:0] i_jump_at,
  input  logic [NJUMP*XW-1:0] i_jump_val,
  input  logic [YW-1:0]       i_irq_line,
  output logic [XW-1:0]       o_raster_x,
  output logic [XW:0]         o_hires_raster_x,
  output logic [XW-1:0]       o_sprite_raster_x,
  output logic [XW-1:0]       o_xpos,
  output logic [YW-1:0]       o_raster_line,
  output logic [YW-1:0]       o_raster_line_d,
  output logic                o_field,
  output logic                o_line_start,
  output logic                o_frame_start,
  output logic                o_irq_match
);

  logic [XW-1:0] r_raster_x, r_sprite_x, r_xpos;
  logic [XW:0]   r_hires;
  logic [YW-1:0] r_line, r_line_d;
  logic          r_field, r_line_start, r_frame_start, r_irq_match, r_cmp_prev;

  logic          w_wrap, w_cmp, w_hires_adv;
  logic [YW:0]   w_eff_last;
  logic [XW-1:0] w_next_xpos;

  assign w_wrap      = i_dot_rising_0 && (r_raster_x >= i_raster_x_max);
  // Odd interlaced fields carry one extra line; one spare bit avoids overflow at max geometry.
  assign w_eff_last  = {1'b0, i_raster_y_max} + (YW+1)'(i_interlace_en & r_field);
  assign w_cmp       = (r_line == i_irq_line);
  assign w_hires_adv = i_dot_rising_0 | (i_dot_rising_2 & i_hires_en);

  // Scan from the top entry down so the lowest matching entry wins.
  always_comb begin
    w_next_xpos = r_xpos + XW'(1);
    for (int i = NJUMP - 1; i >= 0; i--) begin
      if (i_jump_en[i] && (r_raster_x == i_jump_at[i*XW +: XW])) begin
        w_next_xpos = i_jump_val[i*XW +: XW];
      end
    end
  end

  always_ff @(posedge clk_dot4x) begin
    if (i_rst) begin
      r_raster_x    <= '0;
      r_hires       <= '0;
      r_sprite_x    <= i_spr_ofs;
      r_xpos        <= i_xpos_start;
      r_line        <= '0;
      r_line_d      <= '0;
      r_field       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_irq_match   <= 1'b0;
      r_cmp_prev    <= 1'b1;
    end else begin
      r_line_start  <= w_wrap;
      r_frame_start <= 1'b0;
      r_irq_match   <= w_cmp & ~r_cmp_prev;
      r_cmp_prev    <= w_cmp;

      if (!i_clk_phi && (r_line_d != r_line)) begin
        r_line_d <= r_line;
      end

      if (w_wrap) begin
        r_hires <= '0;
      end else if (w_hires_adv) begin
        r_hires <= r_hires + (XW+1)'(1);
      end

      if (i_dot_rising_0) begin
        r_sprite_x <= (r_sprite_x >= i_raster_x_max) ? '0 : r_sprite_x + XW'(1);
      end

      if (w_wrap) begin
        r_raster_x <= '0;
        r_xpos     <= i_xpos_start;
        if ({1'b0, r_line} < w_eff_last) begin
          r_line <= r_line + YW'(1);
        end else begin
          r_line        <= '0;
          r_frame_start <= 1'b1;
          r_field       <= i_interlace_en & ~r_field;
        end
      end else if (i_dot_rising_0) begin
        r_raster_x <= r_raster_x + XW'(1);
        r_xpos     <= w_next_xpos;
      end
    end
  end

  assign o_raster_x        = r_raster_x;
  assign o_hires_raster_x  = r_hires;
  assign o_sprite_raster_x = r_sprite_x;
  assign o_xpos            = r_xpos;
  assign o_raster_line     = r_line;
  assign o_raster_line_d   = r_line_d;
  assign o_field           = r_field;
  assign o_line_start      = r_line_start;
  assign o_frame_start     = r_frame_start;
  assign o_irq_match       = r_irq_match;

endmodule

// File: tb/tb_raster_timing_gen.sv
// tb/tb_raster_timing_gen.sv - directed bench for raster_timing_gen with a cycle-level
// reference model and hand-computed checkpoints.
module tb_raster_timing_gen;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int NJUMP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1, phi = 1'b0, dot0 = 1'b0, dot2 = 1'b0, hires_en = 1'b0, interlace = 1'b0;
  logic [XW-1:0] x_max = 10'd503, xpos_start = 10'h194, spr_ofs = 10'd5;
  logic [YW-1:0] y_max = 9'd311, irq_line = 9'd0;
  logic [NJUMP-1:0] jump_en = '0;
  logic [NJUMP*XW-1:0] jump_at = '0, jump_val = '0;

  logic [XW-1:0] raster_x, sprite_x, xpos;
  logic [XW:0]   hires;
  logic [YW-1:0] line, line_d;
  logic          field, line_start, frame_start, irq_match;

  raster_timing_gen #(.XW(XW), .YW(YW), .NJUMP(NJUMP)) dut (
    .clk_dot4x(clk), .i_rst(rst), .i_clk_phi(phi),
    .i_dot_rising_0(dot0), .i_dot_rising_2(dot2), .i_hires_en(hires_en),
    .i_interlace_en(interlace), .i_raster_x_max(x_max), .i_raster_y_max(y_max),
    .i_xpos_start(xpos_start), .i_spr_ofs(spr_ofs), .i_jump_en(jump_en),
    .i_jump_at(jump_at), .i_jump_val(jump_val), .i_irq_line(irq_line),
    .o_raster_x(raster_x), .o_hires_raster_x(hires), .o_sprite_raster_x(sprite_x),
    .o_xpos(xpos), .o_raster_line(line), .o_raster_line_d(line_d), .o_field(field),
    .o_line_start(line_start), .o_frame_start(frame_start), .o_irq_match(irq_match)
  );

  initial forever #5 clk = ~clk;

  // Reference model: arithmetic restatement of the positional rules.
  int m_x, m_h, m_spr, m_xpos, m_line, m_ld, m_last, m_nx;
  bit m_field, m_ls, m_fs, m_irq, m_prev, m_valid = 1'b0, m_wrap, m_hit, m_found;

  always @(posedge clk) begin
    if (rst) begin
      m_x = 0; m_h = 0; m_line = 0; m_ld = 0; m_field = 0;
      m_ls = 0; m_fs = 0; m_irq = 0; m_prev = 1;
      m_xpos = int'(xpos_start); m_spr = int'(spr_ofs); m_valid = 1;
    end else begin
      m_wrap = dot0 && (m_x >= int'(x_max));
      m_last = int'(y_max) + ((interlace && m_field) ? 1 : 0);
      m_hit  = (m_line == int'(irq_line));
      m_irq  = m_hit && !m_prev;
      m_prev = m_hit;
      if (!phi) m_ld = m_line;
      m_ls = m_wrap;
      m_fs = 0;
      if (m_wrap) m_h = 0;
      else if (dot0 || (dot2 && hires_en)) m_h = (m_h + 1) % 2048;
      if (dot0) m_spr = (m_spr >= int'(x_max)) ? 0 : m_spr + 1;
      if (m_wrap) begin
        m_x = 0;
        m_xpos = int'(xpos_start);
        if (m_line < m_last) m_line = m_line + 1;
        else begin
          m_line = 0;
          m_fs = 1;
          m_field = interlace ? !m_field : 1'b0;
        end
      end else if (dot0) begin
        m_found = 0;
        m_nx = (m_xpos + 1) % 1024;
        for (int i = 0; i < NJUMP; i++) begin
          if (!m_found && jump_en[i] && int'(jump_at[i*XW +: XW]) == m_x) begin
            m_found = 1;
            m_nx = int'(jump_val[i*XW +: XW]);
          end
        end
        m_x = m_x + 1;
        m_xpos = m_nx;
      end
    end
  end

  int errors = 0, checks = 0;
  int n_ls = 0, n_fs = 0, n_irq = 0, n_field_hi = 0, max_line = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit d0, input bit d2);
    dot0 = d0; dot2 = d2;
    @(posedge clk);
    @(negedge clk);
    if (m_valid) begin
      check("raster_x", 32'(raster_x), 32'(m_x));
      check("hires_raster_x", 32'(hires), 32'(m_h));
      check("sprite_raster_x", 32'(sprite_x), 32'(m_spr));
      check("xpos", 32'(xpos), 32'(m_xpos));
      check("raster_line", 32'(line), 32'(m_line));
      check("raster_line_d", 32'(line_d), 32'(m_ld));
      check("field", 32'(field), 32'(m_field));
      check("line_start", 32'(line_start), 32'(m_ls));
      check("frame_start", 32'(frame_start), 32'(m_fs));
      check("irq_match", 32'(irq_match), 32'(m_irq));
    end
    n_ls += int'(line_start === 1'b1);
    n_fs += int'(frame_start === 1'b1);
    n_irq += int'(irq_match === 1'b1);
    n_field_hi += int'(field === 1'b1);
    if (int'(line) > max_line) max_line = int'(line);
    dot0 = 1'b0; dot2 = 1'b0;
  endtask

  task automatic dots(input int n);
    repeat (n) cyc(1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
  endtask

  int ls0, fs0, irq0;

  initial begin
    // Reset state; irq_line == line 0 must not strobe out of reset.
    do_reset();
    check("rst raster_x", 32'(raster_x), 32'd0);
    check("rst xpos", 32'(xpos), 32'h194);
    check("rst sprite", 32'(sprite_x), 32'd5);
    check("rst line", 32'(line), 32'd0);
    irq0 = n_irq;
    idle(3);
    check("rst no irq", 32'(n_irq - irq0), 32'd0);

    // Full line at 504 pixels, then two frames of 312 lines on a short line.
    do_reset();
    ls0 = n_ls; fs0 = n_fs; n_field_hi = 0; max_line = 0;
    dots(503);
    check("t1 x at max", 32'(raster_x), 32'd503);
    dots(1);
    check("t1 wrap x", 32'(raster_x), 32'd0);
    check("t1 wrap line", 32'(line), 32'd1);
    check("t1 wrap strobe", 32'(line_start), 32'd1);
    x_max = 10'd7;
    dots(2488);
    check("t1 frame1", 32'(n_fs - fs0), 32'd1);
    check("t1 frame1 line", 32'(line), 32'd0);
    dots(2496);
    check("t1 frames", 32'(n_fs - fs0), 32'd2);
    check("t1 lines", 32'(n_ls - ls0), 32'd624);
    check("t1 max line", 32'(max_line), 32'd311);
    check("t1 field high", 32'(n_field_hi), 32'd0);

    // Jump table priority.
    x_max = 10'd503;
    do_reset();
    jump_at  = {10'd100, 10'd100, 10'd100, 10'd100};
    jump_val = {10'h3ff, 10'h3fe, 10'h184, 10'h000};
    jump_en  = 4'b0011;
    dots(100);
    check("t2 pre-jump xpos", 32'(xpos), 32'h1f8);
    dots(1);
    check("t2 jump0 xpos", 32'(xpos), 32'h000);
    check("t2 jump0 x", 32'(raster_x), 32'd101);
    dots(1);
    check("t2 post-jump", 32'(xpos), 32'h001);
    dots(402);
    check("t2 wrap xpos", 32'(xpos), 32'h194);
    jump_en = 4'b0010;
    dots(101);
    check("t2 jump1 xpos", 32'(xpos), 32'h184);
    jump_en = 4'b0000;

    // Interlace: even field 262 lines, odd field 263 lines.
    x_max = 10'd3; y_max = 9'd261; interlace = 1'b1;
    do_reset();
    dots(1047);
    check("t3 even last", 32'(line), 32'd261);
    dots(1);
    check("t3 even fs", 32'(frame_start), 32'd1);
    check("t3 field odd", 32'(field), 32'd1);
    dots(1051);
    check("t3 odd last", 32'(line), 32'd262);
    dots(1);
    check("t3 odd fs", 32'(frame_start), 32'd1);
    check("t3 field even", 32'(field), 32'd0);
    interlace = 1'b0; y_max = 9'd311;

    // Hi-res counter.
    x_max = 10'd20; hires_en = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
    end
    check("t4 hires 2x", 32'(hires), 32'd20);
    check("t4 hires x", 32'(raster_x), 32'd10);
    cyc(1'b1, 1'b1);
    check("t4 coincident", 32'(hires), 32'd21);
    dots(9);
    check("t4 pre-wrap", 32'(hires), 32'd30);
    dots(1);
    check("t4 wrap zero", 32'(hires), 32'd0);
    hires_en = 1'b0;
    cyc(1'b0, 1'b1);
    check("t4 hires off", 32'(hires), 32'd0);

    // Raster compare.
    x_max = 10'd3; irq_line = 9'd50;
    do_reset();
    irq0 = n_irq;
    dots(200);
    check("t5 at line 50", 32'(line), 32'd50);
    check("t5 no early irq", 32'(n_irq - irq0), 32'd0);
    idle(1);
    check("t5 irq strobe", 32'(irq_match), 32'd1);
    idle(1);
    check("t5 irq single", 32'(irq_match), 32'd0);
    irq0 = n_irq;
    irq_line = 9'd50;
    idle(3);
    check("t5 rewrite same", 32'(n_irq - irq0), 32'd0);
    irq_line = 9'd51;
    idle(2);
    irq_line = 9'd50;
    idle(2);
    check("t5 rewrite strobe", 32'(n_irq - irq0), 32'd1);

    // Mid-line reset, then delayed line capture on phi low.
    x_max = 10'd503; spr_ofs = 10'd72; irq_line = 9'd1;
    do_reset();
    dots(300);
    check("t6 x 300", 32'(raster_x), 32'd300);
    irq_line = 9'd0;
    rst = 1'b1;
    cyc(1'b1, 1'b0);
    rst = 1'b0;
    check("t6 rst x", 32'(raster_x), 32'd0);
    check("t6 rst sprite", 32'(sprite_x), 32'd72);
    check("t6 rst xpos", 32'(xpos), 32'h194);
    check("t6 rst irq", 32'(irq_match), 32'd0);
    x_max = 10'd3; phi = 1'b1;
    dots(20);
    check("t6 line 5", 32'(line), 32'd5);
    check("t6 line_d held", 32'(line_d), 32'd0);
    phi = 1'b0;
    idle(1);
    check("t6 line_d follows", 32'(line_d), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/raster_timing_gen.md
Name: raster_timing_gen

Overview:
- Parametrised raster position generator for the video core.
- Produces the pixel counter, hi-res counter, sprite-aligned counter, programmable xpos sequence and raster line counter from one dot-4x clock.
- Line and frame geometry, xpos start and jump points, sprite offset and interlace are runtime inputs driven by the chip-model decode, not hard-coded per chip.
- Adds three things not present in the existing raster logic: line/frame strobes, a raster-compare match strobe and interlaced odd-field support.

Parameters:
- XW, 10: width of raster_x, xpos and sprite_raster_x.
- YW, 9: width of raster_line, raster_line_d and irq_line.
- NJUMP, 4: number of xpos jump-table entries.

Ports:
- clk_dot4x  in  1  system clock, dot x4.
- rst  in  1  synchronous, active-high reset.
- clk_phi  in  1  phi level sampled in the clk_dot4x domain.
- dot_rising_0  in  1  pixel advance strobe.
- dot_rising_2  in  1  mid-pixel strobe for the hi-res counter.
- hires_en  in  1  enables dot_rising_2 counting.
- interlace_en  in  1  enables odd-field extra line.
- raster_x_max  in  XW  last pixel index of a line.
- raster_y_max  in  YW  last line index of an even or non-interlaced field.
- xpos_start  in  XW  xpos value at pixel 0 and after reset.
- spr_ofs  in  XW  sprite_raster_x value after reset.
- jump_en  in  NJUMP  per-entry enable.
- jump_at  in  NJUMP*XW  per-entry raster_x trigger; entry i occupies bits [i*XW +: XW].
- jump_val  in  NJUMP*XW  per-entry xpos load value, same packing as jump_at.
- irq_line  in  YW  raster compare value.
- raster_x  out  XW  pixel counter.
- hires_raster_x  out  XW+1  hi-res pixel counter.
- sprite_raster_x  out  XW  offset pixel counter.
- xpos  out  XW  sprite coordinate sequence.
- raster_line  out  YW  current line.
- raster_line_d  out  YW  line delayed to the phi-low phase.
- field  out  1  0 = even field, 1 = odd field.
- line_start  out  1  one-clock strobe on line advance.
- frame_start  out  1  one-clock strobe on wrap to line 0.
- irq_match  out  1  one-clock strobe on raster-compare match.

Behaviour:
- Reset values:
  - raster_x, hires_raster_x, raster_line, raster_line_d, field, all strobes = 0.
  - xpos = xpos_start; sprite_raster_x = spr_ofs.
  - The internal previous-compare flag resets to 1, so no match strobe fires straight out of reset.
- All state changes occur on posedge clk_dot4x. Outputs are registered, with one-clock latency from a strobe input.
- On dot_rising_0 with raster_x < raster_x_max:
  - raster_x increments by 1.
  - xpos loads jump_val[i] for the lowest i with jump_en[i] and raster_x == jump_at[i]; otherwise xpos increments by 1, wrapping modulo 2^XW.
- On dot_rising_0 with raster_x >= raster_x_max (line wrap):
  - raster_x = 0, xpos = xpos_start, line_start = 1.
  - Effective last line = raster_y_max + (interlace_en & field).
  - If raster_line < effective last line: raster_line increments.
  - Otherwise: raster_line = 0 and frame_start = 1. field toggles if interlace_en is set; else field = 0.
  - If raster_x_max is lowered below the current raster_x mid-line, the next dot_rising_0 wraps.
- sprite_raster_x: on every dot_rising_0 it increments, or loads 0 when it is >= raster_x_max. It runs independently of the raster_x wrap.
- hires_raster_x:
  - On a line wrap it is 0. This has priority over everything else.
  - Otherwise it increments by 1 when dot_rising_0 is set, or when dot_rising_2 & hires_en is set.
  - Both strobes in the same clock give a single increment.
  - Wraps modulo 2^(XW+1).
- raster_line_d: when clk_phi = 0 and raster_line_d != raster_line, raster_line_d loads raster_line. Otherwise it holds.
- irq_match:
  - Registered compare: cmp = (raster_line == irq_line).
  - irq_match = cmp & ~cmp_prev, where cmp_prev is the previous clock's cmp.
  - A write to irq_line that equals the current line therefore strobes once.
  - Holding a matching value does not re-strobe.
- Strobes are 1 for exactly one clock. line_start and frame_start assert together at a frame wrap.
- Reset asserted mid-line restores all reset values on the next clock, regardless of the strobe inputs.

Test Plan:
1. x_max = 503, y_max = 311, xpos_start = 0x194, interlace off; run 2 frames -> raster_x sequence 0..503; raster_line 0..311; frame_start exactly twice; line_start 624 times; field stays 0.
2. Jump entry 0: at = 100, val = 0; entry 1: at = 100, val = 0x184, both enabled -> xpos = 0 after raster_x 100→101 (entry 0 has priority); disable entry 0 -> xpos = 0x184.
3. interlace_en = 1, y_max = 261 -> even field ends at line 261, odd field ends at line 262; field toggles at each frame_start.
4. hires_en = 1, dot_rising_2 between each dot_rising_0 -> hires_raster_x = 2*raster_x; coincident strobes advance it by 1; it is 0 after a line wrap.
5. irq_line = 50 -> a single irq_match one clock after raster_line reaches 50; then set irq_line = 50 again mid-line -> no strobe; set irq_line = 51 then back to 50 while on line 50 -> one strobe.
6. Assert rst mid-line at raster_x = 300 with spr_ofs = 72 -> next clock: raster_x = 0, sprite_raster_x = 72, xpos = xpos_start, no irq_match; clk_phi low on line 5 -> raster_line_d follows within one clock.
